lcd_char_queue: RTL and testbench

LCD_CHAR_QUEUE -- requirements
Module: lcd_char_queue

---
 rtl/lcd_char_queue.sv | 140 ++++++++++++++
 tb/tb_lcd_char_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_queue.sv
// lcd_char_queue: character FIFO between the ALU LCD instruction and the LCD
// controller. Characters are pushed when space is available, and a small
// three-state FSM presents them one at a time with a ready/accept handshake.
module lcd_char_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [7:0]    iData,
  input  logic          iData_Valid,
  input  logic          iFlush,
  output logic          oReadyForData,
  output logic [7:0]    oData,
  output logic          oData_Ready,
  input  logic          iLCD_Ready,
  output logic [AW:0]   oCount,
  output logic          oOverflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_BUSY = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic          push_w;
  logic          pop_w;
  logic          ready_w;

  // Space is judged from the registered count only, so a pop this cycle
  // frees a slot no earlier than the next cycle.
  always_comb begin
    ready_w = (count_q != FULL_COUNT);
    push_w  = iData_Valid && ready_w && !iFlush;
    pop_w   = (state_q == PRESENT) && iLCD_Ready;
  end

  // Storage write port; contents need no reset because count gates reads.
  always_ff @(posedge Clock) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= iData;
    end
  end

  // Output handshake FSM: next state and the presented character.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (!iFlush && (count_q != '0)) begin
          state_d = PRESENT;
          data_d  = mem_q[rd_ptr_q];
        end
      end
      PRESENT: begin
        // An accept wins over a flush so the handshake still completes.
        if (iLCD_Ready) begin
          state_d = WAIT_BUSY;
        end else if (iFlush) begin
          state_d = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (iFlush || !iLCD_Ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer, occupancy and sticky overflow next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (iData_Valid & ~ready_w);
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset overriding every other action.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    oReadyForData = ready_w;
    oData         = data_q;
    oData_Ready   = (state_q == PRESENT);
    oCount        = count_q;
    oOverflow     = overflow_q;
  end

endmodule

// File: tb/tb_lcd_char_queue.sv
// Self-checking bench for lcd_char_queue: directed scenarios plus random
// traffic checked against a queue-based behavioural model.
module tb_lcd_char_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          in_rst;
  logic [7:0]    in_d;
  logic          in_v;
  logic          in_flush;
  logic          in_lrdy;
  logic          oReadyForData;
  logic [7:0]    oData;
  logic          oData_Ready;
  logic [AW:0]   oCount;
  logic          oOverflow;

  int errors = 0;
  int checks = 0;

  // Behavioural model: queued characters, handshake phase
  // (0 = idle, 1 = presenting, 2 = waiting for LCD ready to drop),
  // the last presented character and the sticky overflow flag.
  logic [7:0] m_q[$];
  int         m_ph;
  logic [7:0] m_data;
  logic       m_ovf;
  logic [7:0] got_q[$];
  logic [AW:0] exp_cnt;

  lcd_char_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock        (clk),
    .Reset        (in_rst),
    .iData        (in_d),
    .iData_Valid  (in_v),
    .iFlush       (in_flush),
    .oReadyForData(oReadyForData),
    .oData        (oData),
    .oData_Ready  (oData_Ready),
    .iLCD_Ready   (in_lrdy),
    .oCount       (oCount),
    .oOverflow    (oOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then settle 1 time unit past the edge for sampling.
  task automatic step();
    logic full;
    logic popm;
    logic pushm;
    int   ph_n;
    @(posedge clk);
    if (in_rst) begin
      m_q.delete();
      m_ph   = 0;
      m_data = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      full  = (m_q.size() == DEPTH);
      popm  = (m_ph == 1) && in_lrdy;
      pushm = in_v && !full && !in_flush;
      if (in_v && full) m_ovf = 1'b1;
      ph_n = m_ph;
      case (m_ph)
        0: if (!in_flush && m_q.size() != 0) begin ph_n = 1; m_data = m_q[0]; end
        1: if (in_lrdy) ph_n = 2; else if (in_flush) ph_n = 0;
        default: if (in_flush || !in_lrdy) ph_n = 0;
      endcase
      if (popm) $display("[%0t] pop  %02h", $time, m_q[0]);
      if (pushm) $display("[%0t] push %02h", $time, in_d);
      if (in_flush) begin
        $display("[%0t] flush", $time);
        m_q.delete();
      end else begin
        if (popm) void'(m_q.pop_front());
        if (pushm) m_q.push_back(in_d);
      end
      m_ph = ph_n;
    end
    exp_cnt = (AW+1)'(m_q.size());
    #1;
  endtask

  // Alternate iLCD_Ready high/low until n characters are accepted.
  task automatic drain_pulses(input int n);
    got_q.delete();
    for (int c = 0; c < 40 * n && got_q.size() < n; c++) begin
      in_lrdy = (c % 2 == 0);
      if (oData_Ready === 1'b1 && in_lrdy) got_q.push_back(oData);
      step();
    end
    in_lrdy = 1'b0;
    step();
  endtask

  task automatic test_reset();
    in_rst = 1'b1; in_v = 1'b0; in_flush = 1'b0; in_lrdy = 1'b0; in_d = 8'h00;
    step(); step();
    in_rst = 1'b0;
    checks++; if (oCount !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", oCount); end
    checks++; if (oData_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", oData_Ready); end
    checks++; if (oData !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h exp=00", oData); end
    checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", oOverflow); end
    checks++; if (oReadyForData !== 1'b1) begin errors++; $display("FAIL reset_rfd got=%b exp=1", oReadyForData); end
  endtask

  task automatic test_single();
    in_lrdy = 1'b1; in_v = 1'b1; in_d = 8'h41;
    step();
    in_v = 1'b0;
    checks++; if (oCount !== exp_cnt || exp_cnt != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", oCount); end
    checks++; if (oData_Ready !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", oData_Ready); end
    step();
    checks++; if (oData_Ready !== 1'b1) begin errors++; $display("FAIL single_present got=%b exp=1", oData_Ready); end
    checks++; if (oData !== 8'h41) begin errors++; $display("FAIL single_data got=%02h exp=41", oData); end
    step();
    checks++; if (oCount !== '0) begin errors++; $display("FAIL single_popped got=%0d exp=0", oCount); end
    checks++; if (oData_Ready !== 1'b0) begin errors++; $display("FAIL single_wait got=%b exp=0", oData_Ready); end
    in_lrdy = 1'b0;
    step(); step();
  endtask

  task automatic test_fill_overflow();
    in_lrdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_v = 1'b1; in_d = 8'h30 + 8'(i);
      step();
    end
    checks++; if (oCount !== 4'(DEPTH)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", oCount, DEPTH); end
    checks++; if (oReadyForData !== 1'b0) begin errors++; $display("FAIL fill_rfd got=%b exp=0", oReadyForData); end
    checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", oOverflow); end
    in_d = 8'h38;
    step();
    in_v = 1'b0;
    checks++; if (oCount !== 4'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", oCount, DEPTH); end
    checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", oOverflow); end
  endtask

  task automatic test_drain();
    got_q.delete();
    for (int c = 0; c < 200 && m_q.size() != 0; c++) begin
      in_lrdy = (c % 2 == 0);
      if (oData_Ready === 1'b1 && in_lrdy) got_q.push_back(oData);
      step();
      checks++; if (oData_Ready !== (m_ph == 1)) begin errors++; $display("FAIL drain_ready cyc=%0d got=%b exp=%b", c, oData_Ready, m_ph == 1); end
    end
    in_lrdy = 1'b0;
    step();
    checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL drain_num got=%0d exp=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL drain_order idx=%0d got=%02h exp=%02h", i, got_q[i], 8'h30 + 8'(i)); end
    end
    checks++; if (oCount !== '0) begin errors++; $display("FAIL drain_count got=%0d exp=0", oCount); end
  endtask

  task automatic test_hold_ready();
    in_lrdy = 1'b0;
    in_v = 1'b1; in_d = 8'h60; step();
    in_d = 8'h61; step();
    in_v = 1'b0;
    checks++; if (oData_Ready !== 1'b1 || oData !== 8'h60) begin errors++; $display("FAIL hold_present rdy=%b data=%02h exp rdy=1 data=60", oData_Ready, oData); end
    in_lrdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (oData_Ready !== 1'b0 || oCount !== 4'd1) begin errors++; $display("FAIL hold_wait cyc=%0d rdy=%b cnt=%0d exp rdy=0 cnt=1", c, oData_Ready, oCount); end
    end
    in_lrdy = 1'b0;
    drain_pulses(1);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h61) begin errors++; $display("FAIL hold_next n=%0d exp one char 61", got_q.size()); end
  endtask

  task automatic test_flush();
    in_lrdy = 1'b0;
    in_v = 1'b1; in_d = 8'h48; step();
    in_d = 8'h49; step();
    in_v = 1'b1; in_d = 8'h4A; in_flush = 1'b1; step();
    in_v = 1'b0; in_flush = 1'b0;
    checks++; if (oCount !== '0) begin errors++; $display("FAIL flush_count got=%0d exp=0", oCount); end
    checks++; if (oData_Ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", oData_Ready); end
    checks++; if (oOverflow !== m_ovf || m_ovf !== 1'b1) begin errors++; $display("FAIL flush_ovf got=%b exp=1", oOverflow); end
    step(); step();
    checks++; if (oData_Ready !== 1'b0) begin errors++; $display("FAIL flush_stays_idle got=%b exp=0", oData_Ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq[$];
    in_rst = 1'b1; step(); in_rst = 1'b0;
    in_lrdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin in_v = 1'b1; in_d = 8'h50 + 8'(i); step(); end
    in_v = 1'b0;
    drain_pulses(3);
    for (int i = 0; i < 3; i++) begin in_v = 1'b1; in_d = 8'h58 + 8'(i); step(); end
    in_v = 1'b0;
    checks++; if (oCount !== exp_cnt || exp_cnt != DEPTH) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", oCount, DEPTH); end
    exp_seq.delete();
    for (int i = 0; i < DEPTH; i++) exp_seq.push_back(8'h53 + 8'(i));
    // The character already presented stays queued until accepted.
    drain_pulses(DEPTH);
    checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL wrap_num got=%0d exp=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_seq[i]) begin errors++; $display("FAIL wrap_order idx=%0d got=%02h exp=%02h", i, got_q[i], exp_seq[i]); end
    end
  endtask

  task automatic test_reset_mid();
    in_lrdy = 1'b0;
    in_v = 1'b1; in_d = 8'h70; step();
    in_v = 1'b0; step();
    checks++; if (oData_Ready !== 1'b1) begin errors++; $display("FAIL mid_present got=%b exp=1", oData_Ready); end
    in_rst = 1'b1; in_lrdy = 1'b1; step();
    in_rst = 1'b0;
    checks++; if (oData_Ready !== 1'b0 || oCount !== '0 || oData !== 8'h00) begin errors++; $display("FAIL mid_reset rdy=%b cnt=%0d data=%02h exp 0/0/00", oData_Ready, oCount, oData); end
    step(); step();
    checks++; if (oData_Ready !== 1'b0) begin errors++; $display("FAIL mid_lost got=%b exp=0", oData_Ready); end
    in_lrdy = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_rst   = ($urandom_range(99) == 0);
      in_v     = $urandom_range(1);
      in_d     = 8'($urandom);
      in_flush = ($urandom_range(24) == 0);
      in_lrdy  = ($urandom_range(2) != 0);
      step();
      checks++; if (oCount !== exp_cnt) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, oCount, exp_cnt); end
      checks++; if (oReadyForData !== (m_q.size() != DEPTH)) begin errors++; $display("FAIL rnd_rfd cyc=%0d got=%b", c, oReadyForData); end
      checks++; if (oData_Ready !== (m_ph == 1)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, oData_Ready, m_ph == 1); end
      checks++; if (oData !== m_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%02h exp=%02h", c, oData, m_data); end
      checks++; if (oOverflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, oOverflow, m_ovf); end
    end
    in_rst = 1'b0; in_v = 1'b0; in_flush = 1'b0; in_lrdy = 1'b0;
  endtask

  initial begin
    m_ph = 0; m_data = 8'h00; m_ovf = 1'b0; exp_cnt = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_drain();
    test_hold_ready();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
